// File: rtl/nonce_dispatch.sv
// Nonce dispatcher: slices a job's nonce range across hasher lanes and funnels hits into a golden-nonce FIFO.
// Define NONCE_DISPATCH_STATS_EN to add the saturating 48-bit hash_count output.
//
// state | meaning
// IDLE  | after reset, no job loaded
// RUN   | issuing nonces every ISSUE_INTERVAL cycles
// DRAIN | issuing stopped, waiting for in-flight results and pending hits
// DONE  | job finished, waiting for job_start
module nonce_dispatch #(
   parameter int CHANNELS        = 4,
   parameter int ISSUE_INTERVAL  = 32,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int INFLIGHT_W      = 10
) (
   input  logic                     hash_clk,
   input  logic                     reset_n,
   input  logic                     job_start,
   input  logic                     job_abort,
   input  logic [31:0]              nonce_min,
   input  logic [31:0]              nonce_max,
   input  logic [31:0]              target,
   output logic [CHANNELS-1:0]      issue_valid,
   output logic [32*CHANNELS-1:0]   issue_nonce,
   input  logic [CHANNELS-1:0]      res_valid,
   input  logic [32*CHANNELS-1:0]   res_nonce,
   input  logic [32*CHANNELS-1:0]   res_hash_hi,
   output logic                     gn_valid,
   input  logic                     gn_ready,
   output logic [31:0]              gn_nonce,
   output logic                     busy,
   output logic                     done,
   output logic                     gn_overflow
`ifdef NONCE_DISPATCH_STATS_EN
   ,
   output logic [47:0]              hash_count
`endif
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int TW    = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
   localparam int CW    = $clog2(CHANNELS + 1);
   localparam int IW1   = INFLIGHT_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state;
   logic [TW-1:0]            timer;
   logic [31:0]              next_nonce;
   logic [31:0]              nmax_q;
   logic [31:0]              target_q;
   logic [INFLIGHT_W-1:0]    inflight;
   logic [CHANNELS-1:0]      pend_full;
   logic [31:0]              pend [CHANNELS];
   logic [31:0]              mem [DEPTH];
   logic [FIFO_DEPTH_LOG2:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2:0] rd_ptr;
   logic                     overflow;

   logic [CHANNELS-1:0]      hit;
   logic [CHANNELS-1:0]      lane_ok;
   logic [CHANNELS-1:0]      drain_take;
   logic [31:0]              drain_data;
   logic                     last_slot;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     fifo_pop;
   logic                     fifo_push;
   logic [CW-1:0]            res_cnt;
   logic [IW1-1:0]           inflight_sum;
   logic [INFLIGHT_W-1:0]    inflight_nxt;

   function automatic logic [CW-1:0] popcnt(input logic [CHANNELS-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < CHANNELS; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
   assign fifo_pop    = !fifo_empty && gn_ready;
   assign res_cnt     = popcnt(res_valid);
   assign gn_valid    = !fifo_empty;
   assign gn_nonce    = gn_valid ? mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]] : 32'h0;
   assign busy        = (state == RUN) || (state == DRAIN);
   assign done        = (state == DONE);
   assign gn_overflow = overflow;

   // Range compares use 33 bits so a slot near 0xFFFFFFFF never wraps back to 0.
   always_comb begin
      hit        = '0;
      lane_ok    = '0;
      drain_take = '0;
      drain_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         hit[k]     = res_valid[k] && (res_hash_hi[32*k +: 32] <= target_q);
         lane_ok[k] = ({1'b0, next_nonce} + 33'(k)) <= {1'b0, nmax_q};
      end
      last_slot = ({1'b0, next_nonce} + 33'(CHANNELS)) > {1'b0, nmax_q};
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (pend_full[k]) begin
            drain_take = CHANNELS'(1) << k;
            drain_data = pend[k];
         end
      end
      if (fifo_full && !fifo_pop) drain_take = '0;
      fifo_push    = |drain_take;
      inflight_sum = {1'b0, inflight} + IW1'(popcnt(issue_valid));
      inflight_nxt = (inflight_sum < IW1'(res_cnt)) ? '0 : INFLIGHT_W'(inflight_sum - IW1'(res_cnt));
   end

   always_ff @(posedge hash_clk) begin
      if (fifo_push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= drain_data;
   end

   always_ff @(posedge hash_clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         timer       <= '0;
         next_nonce  <= '0;
         nmax_q      <= '0;
         target_q    <= '0;
         inflight    <= '0;
         issue_valid <= '0;
         issue_nonce <= '0;
         pend_full   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow    <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) pend[k] <= '0;
      end else begin
         issue_valid <= '0;
         inflight    <= inflight_nxt;
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         for (int k = 0; k < CHANNELS; k++) begin
            if (hit[k]) begin
               if (pend_full[k] && !drain_take[k]) begin
                  overflow <= 1'b1;
               end else begin
                  pend[k]      <= res_nonce[32*k +: 32];
                  pend_full[k] <= 1'b1;
               end
            end else if (drain_take[k]) begin
               pend_full[k] <= 1'b0;
            end
         end
         case (state)
            IDLE, DONE: begin
               if (job_start) begin
                  state      <= RUN;
                  nmax_q     <= nonce_max;
                  target_q   <= target;
                  next_nonce <= nonce_min;
                  timer      <= '0;
                  inflight   <= '0;
                  overflow   <= 1'b0;
               end
            end
            RUN: begin
               if (timer == '0) begin
                  timer      <= TW'(ISSUE_INTERVAL - 1);
                  next_nonce <= next_nonce + 32'(CHANNELS);
                  for (int k = 0; k < CHANNELS; k++) begin
                     if (lane_ok[k]) begin
                        issue_valid[k]          <= 1'b1;
                        issue_nonce[32*k +: 32] <= next_nonce + 32'(k);
                     end
                  end
                  if (last_slot) state <= DRAIN;
               end else begin
                  timer <= timer - TW'(1);
               end
               if (job_abort) state <= DRAIN;
            end
            DRAIN: begin
               if (inflight == '0 && issue_valid == '0 && res_valid == '0 && pend_full == '0)
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NONCE_DISPATCH_STATS_EN
   logic [48:0] hc_sum;
   assign hc_sum = {1'b0, hash_count} + 49'(res_cnt);

   always_ff @(posedge hash_clk) begin
      if (!reset_n)
         hash_count <= '0;
      else if (job_start && (state == IDLE || state == DONE))
         hash_count <= '0;
      else
         hash_count <= hc_sum[48] ? '1 : hc_sum[47:0];
   end
`endif

endmodule

// File: doc/nonce_dispatch.md
NONCE_DISPATCH -- requirements
Module: nonce_dispatch

Interface
REQ-001 Parameter CHANNELS, default 4, number of external hasher lanes (1..8).
REQ-002 Parameter ISSUE_INTERVAL, default 32, cycles between issue slots (1..64); equals the hasher's LOOP.
REQ-003 Parameter FIFO_DEPTH_LOG2, default 3, golden-nonce FIFO depth 2**N (1..6).
REQ-004 Parameter INFLIGHT_W, default 10, width of the in-flight counter.
REQ-005 hash_clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 job_start  in  1  pulse, loads a new job; honoured only in IDLE or DONE.
REQ-008 job_abort  in  1  pulse, stops issuing; honoured only in RUN.
REQ-009 nonce_min, nonce_max  in  32 each  inclusive job range, sampled on job_start.
REQ-010 target  in  32  hit threshold for the hash top word, sampled on job_start.
REQ-011 issue_valid  out  CHANNELS  per-lane one-cycle issue strobe.
REQ-012 issue_nonce  out  32*CHANNELS  lane k nonce at bits [32k+31:32k].
REQ-013 res_valid  in  CHANNELS; res_nonce  in  32*CHANNELS; res_hash_hi  in  32*CHANNELS  hasher results (hash2[255:224]).
REQ-014 gn_valid  out  1; gn_ready  in  1; gn_nonce  out  32  golden-nonce output stream.
REQ-015 busy  out  1; done  out  1; gn_overflow  out  1 (sticky).

Function
REQ-016 States are IDLE, RUN, DRAIN and DONE; busy is high in RUN and DRAIN, and done is high in DONE.
REQ-017 IDLE/DONE + job_start -> RUN: latch nonce_min/nonce_max/target, next_nonce=nonce_min, slot timer=0, clear gn_overflow and in-flight count; FIFO contents are kept.
REQ-018 In RUN, on the cycle the timer is 0, lane k asserts issue_valid[k] with issue_nonce[k]=next_nonce+k if next_nonce+k<=nonce_max (33-bit compare, no wrap); next_nonce then advances by CHANNELS.
REQ-019 The timer counts 0..ISSUE_INTERVAL-1 and wraps; issue_nonce holds its value between strobes.
REQ-020 RUN -> DRAIN in the cycle after the slot that issues nonce_max, or on job_abort (a slot coinciding with job_abort is still issued); nonce_max=0xFFFFFFFF terminates without wrapping to 0.
REQ-021 The in-flight counter adds popcount(issue_valid) and subtracts popcount(res_valid) in the same cycle; underflow saturates at 0.
REQ-022 DRAIN -> DONE when in-flight==0, res_valid==0 and all pending registers are empty; done stays high until job_start.
REQ-023 A hit is res_valid[k] && res_hash_hi[k] <= target (unsigned); res_nonce[k] is captured into lane pending register pend[k] on the next edge.
REQ-024 A hit on a lane whose pend[k] is full and not drained that cycle is dropped and sets gn_overflow.
REQ-025 Each cycle, the lowest-index full pend[k] is written to the FIFO if it is not full (with simultaneous pop the FIFO counts as not full); the FIFO keeps pend order.
REQ-026 The FIFO is first-word-fall-through: gn_valid equals not-empty, and a pop occurs on gn_valid && gn_ready.
REQ-027 Latency from a res_valid hit edge to gn_valid high is 2 cycles with an empty FIFO and no contention.
REQ-028 res_valid asserted in IDLE or DONE is checked against the last latched target; in IDLE after reset, target=0.

Reset
REQ-029 With reset_n low at an edge: state=IDLE, issue_valid=0, issue_nonce=0, next_nonce=0, timer=0, in-flight=0, pend empty, FIFO empty, gn_valid=0, gn_nonce=0, busy=0, done=0, gn_overflow=0.
REQ-030 Reset has priority over job_start, job_abort and all results in the same cycle, including reset in the middle of RUN.

Configuration
REQ-031 When macro NONCE_DISPATCH_STATS_EN is defined, the block has an extra output hash_count (48 bits) that counts popcount(res_valid) per cycle, clears on job_start and reset, and saturates at all-ones.
REQ-032 When NONCE_DISPATCH_STATS_EN is not defined, the hash_count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-033 Run CHANNELS=4, ISSUE_INTERVAL=2, range 0x10..0x19 -> strobes at 0x10-13, 0x14-17, then 0x18-19 with lane mask 0011, then DRAIN.
REQ-034 Use nonce_max=0xFFFFFFFF, nonce_min=0xFFFFFFFE -> exactly two nonces are issued, no wrap to 0, then DRAIN.
REQ-035 Three lanes hit in the same cycle with target=0x0000FFFF -> FIFO order is lane0, lane1, lane2, with gn_valid 2 cycles after the results.
REQ-036 Hold gn_ready=0 and feed 2**FIFO_DEPTH_LOG2+CHANNELS+1 hits on lane 0 -> the FIFO fills, pend[0] holds one entry, gn_overflow=1, and the drained values are in order.
REQ-037 Pulse job_abort mid-RUN with 8 in flight, then return 8 results -> DONE asserts exactly after the last result and pending drain.
REQ-038 Drive reset_n low during RUN with FIFO non-empty -> the next cycle shows all REQ-029 values and a following job_start is accepted.
